// File: rtl/fact_pkg.sv
// fact_pkg: shared definitions for the factorial core.
//   - default operand/result widths and the largest representable operand
//   - controller state encoding (state_e)
//   - datapath operation select (dp_op_e) passed from control to fact_dp
package fact_pkg;

  localparam int N_W_DEF   = 4;
  localparam int R_W_DEF   = 32;
  localparam int N_MAX_DEF = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    DP_HOLD    = 2'd0,  // keep counter/product
    DP_CAPTURE = 2'd1,  // counter <= n, product cleared
    DP_SEED    = 2'd2,  // product <= counter, counter--
    DP_STEP    = 2'd3   // product <= product * counter, counter--
  } dp_op_e;

endpackage

// File: rtl/fact_dp.sv
// fact_dp: factorial datapath.
//   clk, rst    : clock, asynchronous active-low reset
//   op          : operation select from the controller
//   n           : operand, loaded into the counter on DP_CAPTURE
//   product     : running product register
//   cnt_le1     : counter <= 1
//   n_gt_max    : captured operand exceeds N_MAX (valid while counter holds n)
module fact_dp
  import fact_pkg::*;
#(
  parameter int N_W   = N_W_DEF,
  parameter int R_W   = R_W_DEF,
  parameter int N_MAX = N_MAX_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  dp_op_e         op,
  input  logic [N_W-1:0] n,
  output logic [R_W-1:0] product,
  output logic           cnt_le1,
  output logic           n_gt_max
);

  localparam logic [N_W-1:0] ONE    = N_W'(1);
  localparam logic [N_W-1:0] NMAX_V = N_W'(N_MAX);

  logic [N_W-1:0] counter_q, counter_d;
  logic [R_W-1:0] product_q, product_d;
  logic [R_W-1:0] mult;

  always_comb begin
    // single-cycle R_W x N_W multiply, truncated to R_W
    mult      = product_q * R_W'(counter_q);
    counter_d = counter_q;
    product_d = product_q;
    case (op)
      DP_CAPTURE: begin
        counter_d = n;
        product_d = '0;
      end
      DP_SEED: begin
        product_d = R_W'(counter_q);
        counter_d = counter_q - ONE;
      end
      DP_STEP: begin
        product_d = mult;
        counter_d = counter_q - ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      counter_q <= '0;
      product_q <= '0;
    end else begin
      counter_q <= counter_d;
      product_q <= product_d;
    end
  end

  assign product  = product_q;
  assign cnt_le1  = (counter_q <= ONE);
  assign n_gt_max = (counter_q > NMAX_V);

endmodule

// File: rtl/fact_core.sv
// fact_core: iterative factorial, one multiply per clock.
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset
//   go, n   : start request and operand, sampled together in IDLE/DONE
//   busy    : high in LOAD and CALC
//   done    : sticky completion flag, cleared by the next accepted go
//   err     : sticky overflow flag (n > N_MAX), valid with done
//   result  : n!, valid with done
//   int_req : one-cycle pulse after entering DONE
module fact_core
  import fact_pkg::*;
#(
  parameter int N_W   = N_W_DEF,
  parameter int R_W   = R_W_DEF,
  parameter int N_MAX = N_MAX_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go,
  input  logic [N_W-1:0] n,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [R_W-1:0] result,
  output logic           int_req
);

  state_e         state_q, state_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [R_W-1:0] result_q, result_d;
  logic           int_req_q, int_req_d;

  dp_op_e         dp_op;
  logic [R_W-1:0] product;
  logic           cnt_le1;
  logic           n_gt_max;

  fact_dp #(
    .N_W  (N_W),
    .R_W  (R_W),
    .N_MAX(N_MAX)
  ) u_dp (
    .clk     (clk),
    .rst     (rst),
    .op      (dp_op),
    .n       (n),
    .product (product),
    .cnt_le1 (cnt_le1),
    .n_gt_max(n_gt_max)
  );

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    result_d  = result_q;
    int_req_d = 1'b0;
    dp_op     = DP_HOLD;
    case (state_q)
      IDLE, DONE: begin
        if (go) begin
          dp_op    = DP_CAPTURE;
          done_d   = 1'b0;
          err_d    = 1'b0;
          result_d = '0;
          busy_d   = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        // LOAD folds the first multiply (1 * n) and finishes 0!/1! directly,
        // giving a latency of max(n,1)+1 edges from the go sample to done.
        if (n_gt_max) begin
          err_d     = 1'b1;
          result_d  = '0;
          done_d    = 1'b1;
          int_req_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = DONE;
        end else if (cnt_le1) begin
          result_d  = R_W'(1);
          done_d    = 1'b1;
          int_req_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = DONE;
        end else begin
          dp_op   = DP_SEED;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_le1) begin
          result_d  = product;
          done_d    = 1'b1;
          int_req_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = DONE;
        end else begin
          dp_op = DP_STEP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      result_q  <= '0;
      int_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      result_q  <= result_d;
      int_req_q <= int_req_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign result  = result_q;
  assign int_req = int_req_q;

endmodule

// File: tb/tb_fact_core.sv
// tb_fact_core: directed self-checking bench for fact_core.
module tb_fact_core;

  localparam int N_W   = 4;
  localparam int R_W   = 32;
  localparam int N_MAX = 12;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           go  = 1'b0;
  logic [N_W-1:0] n   = '0;
  logic           busy, done, err, int_req;
  logic [R_W-1:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fact_core #(
    .N_W  (N_W),
    .R_W  (R_W),
    .N_MAX(N_MAX)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .go     (go),
    .n      (n),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .result (result),
    .int_req(int_req)
  );

  task automatic check(input string tag, input logic [R_W-1:0] got, input logic [R_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Start one computation and follow it to DONE. With poke set, go is pulsed
  // with a different operand two edges into CALC; it must be ignored.
  task automatic run_fact(input logic [N_W-1:0] nv, input logic [R_W-1:0] exp_res,
                          input logic exp_err, input bit poke);
    int lat;
    int bcnt;
    int exp_lat;
    exp_lat = (nv > N_MAX) ? 2 : ((nv < 2) ? 2 : nv + 1);
    go = 1'b1;
    n  = nv;
    tick;
    go   = 1'b0;
    n    = ~nv;
    lat  = 1;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      if (poke && lat == 3) begin
        go = 1'b1;
        n  = 4'd3;
      end else begin
        go = 1'b0;
      end
      tick;
      lat++;
    end
    go = 1'b0;
    check("done",        done,    1'b1);
    check("latency",     lat,     exp_lat);
    check("busy_cycles", bcnt,    exp_lat - 1);
    check("result",      result,  exp_res);
    check("err",         err,     exp_err);
    check("int_req",     int_req, 1'b1);
    check("busy_off",    busy,    1'b0);
    tick;
    check("int_req_1cyc", int_req, 1'b0);
    check("hold_done",    done,    1'b1);
    check("hold_result",  result,  exp_res);
    check("hold_err",     err,     exp_err);
  endtask

  initial begin
    int lat;
    // reset state
    #12;
    check("rst_busy",    busy,    1'b0);
    check("rst_done",    done,    1'b0);
    check("rst_err",     err,     1'b0);
    check("rst_result",  result,  '0);
    check("rst_int_req", int_req, 1'b0);
    tick;
    rst = 1'b1;
    tick;

    run_fact(4'd5,  32'd120,       1'b0, 1'b0);
    run_fact(4'd0,  32'd1,         1'b0, 1'b0);
    run_fact(4'd1,  32'd1,         1'b0, 1'b0);
    run_fact(4'd2,  32'd2,         1'b0, 1'b0);
    run_fact(4'd12, 32'h1C8CFC00,  1'b0, 1'b0);
    run_fact(4'd13, 32'd0,         1'b1, 1'b0);
    run_fact(4'd7,  32'd5040,      1'b0, 1'b0);
    run_fact(4'd15, 32'd0,         1'b1, 1'b0);
    run_fact(4'd6,  32'd720,       1'b0, 1'b1);

    // reset in the middle of a 10! computation
    go = 1'b1;
    n  = 4'd10;
    tick;
    go = 1'b0;
    repeat (4) tick;
    check("pre_rst_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    check("arst_busy",    busy,    1'b0);
    check("arst_done",    done,    1'b0);
    check("arst_err",     err,     1'b0);
    check("arst_result",  result,  '0);
    check("arst_int_req", int_req, 1'b0);
    repeat (3) begin
      tick;
      check("rst_no_int", int_req, 1'b0);
      check("rst_no_done", done, 1'b0);
    end
    rst = 1'b1;
    run_fact(4'd4, 32'd24, 1'b0, 1'b0);

    // go held high: restart once per DONE visit
    go = 1'b1;
    n  = 4'd3;
    tick;
    lat = 1;
    for (int p = 0; p < 3; p++) begin
      while (!done && lat < 40) begin
        tick;
        lat++;
      end
      check("held_lat",    lat,     4);
      check("held_result", result,  32'd6);
      check("held_int",    int_req, 1'b1);
      tick;
      lat = 1;
      check("held_restart_done", done,    1'b0);
      check("held_int_off",      int_req, 1'b0);
      check("held_busy",         busy,    1'b1);
    end
    go = 1'b0;
    while (!done && lat < 40) begin
      tick;
      lat++;
    end
    check("held_last_lat",    lat,     4);
    check("held_last_result", result,  32'd6);
    check("held_last_int",    int_req, 1'b1);
    tick;
    check("held_no_repulse", int_req, 1'b0);
    tick;
    check("held_no_repulse2", int_req, 1'b0);
    check("held_done_sticky", done,    1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
